// File: rtl/tmds_encoder.sv
// TMDS encoder for one HDMI/DVI channel: 8-bit pixel byte -> 10-bit DC-balanced
// symbol, or one of four control tokens during blanking. One symbol per clock.
// Ports: clk_in (pixel clock), rst_n_in (async active-low reset), data_in[7:0]
//        (pixel byte, used when ve_in=1), control_in[1:0] ({C1,C0}, used when
//        ve_in=0), ve_in (video enable), tmds_out[9:0] (registered symbol).
// Latency: 1 cycle. No backpressure: a symbol is produced every cycle.

// Transition-minimisation stage: picks the XOR or XNOR chain, whichever gives
// fewer transitions, and flags the choice in q_m[8] (1 = XOR, 0 = XNOR).
// Ports: data[7:0] (input byte), q_m[8:0] (transition-minimised word).
// Purely combinational.
module tm_choice (
  input  logic [7:0] data,
  output logic [8:0] q_m
);

  logic [3:0] ones;
  logic       use_xnor;

  always_comb begin
    ones = 4'd0;
    for (int i = 0; i < 8; i++) begin
      ones = ones + {3'b000, data[i]};
    end
  end

  // XNOR when the byte is ones-heavy; a tie is broken by bit 0 so that the
  // decision is a pure function of the byte.
  assign use_xnor = (ones > 4'd4) || ((ones == 4'd4) && !data[0]);

  always_comb begin
    q_m    = '0;
    q_m[0] = data[0];
    for (int i = 1; i < 8; i++) begin
      q_m[i] = use_xnor ? ~(q_m[i-1] ^ data[i]) : (q_m[i-1] ^ data[i]);
    end
    q_m[8] = ~use_xnor;
  end

endmodule

module tmds_encoder (
  input  logic       clk_in,
  input  logic       rst_n_in,
  input  logic [7:0] data_in,
  input  logic [1:0] control_in,
  input  logic       ve_in,
  output logic [9:0] tmds_out
);

  logic [8:0]        q_m;
  logic [3:0]        n1;
  logic [3:0]        n0;
  logic signed [4:0] diff;       // n1 - n0, range -8..+8
  logic signed [4:0] tally;      // running disparity of the emitted stream
  logic signed [4:0] tally_nxt;
  logic [9:0]        sym_nxt;
  logic              tally_zero;
  logic              tally_pos;
  logic              tally_neg;
  logic              balanced;
  logic              case_a;
  logic              case_b;

  tm_choice u_tm_choice (
    .data (data_in),
    .q_m  (q_m)
  );

  always_comb begin
    n1 = 4'd0;
    for (int i = 0; i < 8; i++) begin
      n1 = n1 + {3'b000, q_m[i]};
    end
  end

  assign n0   = 4'd8 - n1;
  assign diff = $signed({1'b0, n1}) - $signed({1'b0, n0});

  assign tally_zero = (tally == 5'sd0);
  assign tally_neg  = tally[4];
  assign tally_pos  = !tally_neg && !tally_zero;
  assign balanced   = (n1 == n0);

  assign case_a = tally_zero || balanced;
  // Invert the data bits when that pulls the running disparity back to zero.
  assign case_b = (tally_pos && (n1 > n0)) || (tally_neg && (n0 > n1));

  always_comb begin
    sym_nxt   = '0;
    tally_nxt = tally;
    if (!ve_in) begin
      tally_nxt = 5'sd0;
      case (control_in)
        2'b00:   sym_nxt = 10'h354;
        2'b01:   sym_nxt = 10'h0AB;
        2'b10:   sym_nxt = 10'h154;
        default: sym_nxt = 10'h2AB;
      endcase
    end else if (case_a) begin
      sym_nxt = {~q_m[8], q_m[8], (q_m[8] ? q_m[7:0] : ~q_m[7:0])};
      tally_nxt = q_m[8] ? (tally + diff) : (tally - diff);
    end else if (case_b) begin
      sym_nxt   = {1'b1, q_m[8], ~q_m[7:0]};
      // bits 9:8 = 1,q_m[8] add +2 to disparity only when q_m[8] is set
      tally_nxt = tally + (q_m[8] ? 5'sd2 : 5'sd0) - diff;
    end else begin
      sym_nxt   = {1'b0, q_m[8], q_m[7:0]};
      // bits 9:8 = 0,q_m[8] subtract 2 from disparity only when q_m[8] is clear
      tally_nxt = tally - (q_m[8] ? 5'sd0 : 5'sd2) + diff;
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      tmds_out <= '0;
      tally    <= '0;
    end else begin
      tmds_out <= sym_nxt;
      tally    <= tally_nxt;
    end
  end

endmodule

// File: tb/tb_tmds_encoder.sv
// Self-checking bench for tmds_encoder: directed vectors with hand-computed
// symbols and tallies, then a random soak against a behavioural model with
// symbol decode-back and disparity-bound checks.
module tb_tmds_encoder;

  logic       clk_in;
  logic       rst_n_in;
  logic [7:0] data_in;
  logic [1:0] control_in;
  logic       ve_in;
  logic [9:0] tmds_out;

  int n_checks;
  int n_fail;

  tmds_encoder dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .data_in    (data_in),
    .control_in (control_in),
    .ve_in      (ve_in),
    .tmds_out   (tmds_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", tag, got, got, exp, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  function automatic int dut_tally();
    return int'($signed(dut.tally));
  endfunction

  // Reference encoder: returns the symbol and the updated disparity.
  task automatic model_step(input logic [7:0] d, input int t_in,
                            output logic [9:0] sym, output int t_out);
    int         ones_d;
    int         k1;
    int         k0;
    logic       xn;
    logic [7:0] q;
    logic       q8;
    ones_d = 0;
    for (int i = 0; i < 8; i++) ones_d += d[i];
    xn   = (ones_d > 4) || (ones_d == 4 && d[0] == 1'b0);
    q[0] = d[0];
    for (int i = 1; i < 8; i++) q[i] = xn ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    q8 = ~xn;
    k1 = 0;
    for (int i = 0; i < 8; i++) k1 += q[i];
    k0 = 8 - k1;
    if (t_in == 0 || k1 == k0) begin
      if (q8) begin
        sym   = {2'b01, q};
        t_out = t_in + k1 - k0;
      end else begin
        sym   = {2'b10, ~q};
        t_out = t_in + k0 - k1;
      end
    end else if ((t_in > 0 && k1 > k0) || (t_in < 0 && k0 > k1)) begin
      sym   = {1'b1, q8, ~q};
      t_out = t_in + (q8 ? 2 : 0) + k0 - k1;
    end else begin
      sym   = {1'b0, q8, q};
      t_out = t_in - (q8 ? 0 : 2) + k1 - k0;
    end
  endtask

  // Receiver-side decode of a data symbol.
  function automatic logic [7:0] decode(input logic [9:0] sym);
    logic [7:0] q;
    logic [7:0] d;
    q    = sym[9] ? ~sym[7:0] : sym[7:0];
    d[0] = q[0];
    for (int i = 1; i < 8; i++) d[i] = sym[8] ? (q[i] ^ q[i-1]) : ~(q[i] ^ q[i-1]);
    return d;
  endfunction

  function automatic int disparity(input logic [9:0] sym);
    int ones;
    ones = 0;
    for (int i = 0; i < 10; i++) ones += sym[i];
    return ones - (10 - ones);
  endfunction

  logic [9:0] ctrl_tok [4];
  logic [9:0] exp_sym;
  int         m_tally;
  int         m_next;
  int         run_disp;
  logic [7:0] d_prev;
  logic       ve_prev;

  initial begin
    n_checks = 0;
    n_fail   = 0;
    ctrl_tok[0] = 10'h354;
    ctrl_tok[1] = 10'h0AB;
    ctrl_tok[2] = 10'h154;
    ctrl_tok[3] = 10'h2AB;

    // Reset held with random inputs toggling.
    rst_n_in   = 1'b0;
    data_in    = 8'h00;
    control_in = 2'b00;
    ve_in      = 1'b0;
    for (int i = 0; i < 4; i++) begin
      data_in    = 8'($urandom);
      control_in = 2'($urandom);
      ve_in      = 1'($urandom);
      step();
      check("reset_sym", int'(tmds_out), 0);
    end
    check("reset_tally", dut_tally(), 0);

    rst_n_in   = 1'b1;
    ve_in      = 1'b0;
    control_in = 2'b00;
    step();
    check("first_after_reset", int'(tmds_out), 'h354);

    // Control tokens on consecutive cycles.
    for (int c = 0; c < 4; c++) begin
      control_in = 2'(c);
      data_in    = 8'($urandom);
      step();
      check($sformatf("ctrl_%0d", c), int'(tmds_out), int'(ctrl_tok[c]));
      check($sformatf("ctrl_tally_%0d", c), dut_tally(), 0);
    end

    // Repeated 0x00 from tally 0: cases A, B, C in turn.
    ve_in      = 1'b1;
    data_in    = 8'h00;
    control_in = 2'b11;
    step();
    check("zero_1_sym", int'(tmds_out), 'h100);
    check("zero_1_tally", dut_tally(), -8);
    step();
    check("zero_2_sym", int'(tmds_out), 'h3FF);
    check("zero_2_tally", dut_tally(), 2);
    step();
    check("zero_3_sym", int'(tmds_out), 'h100);
    check("zero_3_tally", dut_tally(), -6);

    // One blanking cycle clears the tally.
    ve_in      = 1'b0;
    control_in = 2'b01;
    step();
    check("blank_sym", int'(tmds_out), 'h0AB);
    check("blank_tally", dut_tally(), 0);
    ve_in   = 1'b1;
    data_in = 8'h00;
    step();
    check("after_blank_sym", int'(tmds_out), 'h100);
    check("after_blank_tally", dut_tally(), -8);

    // Single 0xFF from tally 0.
    ve_in = 1'b0;
    step();
    ve_in   = 1'b1;
    data_in = 8'hFF;
    step();
    check("ff_sym", int'(tmds_out), 'h200);
    check("ff_tally", dut_tally(), -8);

    // Mid-stream reset: immediate clear, tally discarded.
    data_in = 8'h00;
    step();
    check("pre_rst_tally", dut_tally(), 2);
    #2;
    rst_n_in = 1'b0;
    #1;
    check("midrst_sym", int'(tmds_out), 0);
    check("midrst_tally", dut_tally(), 0);
    @(negedge clk_in);
    rst_n_in = 1'b1;
    step();
    check("post_rst_sym", int'(tmds_out), 'h100);
    check("post_rst_tally", dut_tally(), -8);

    // Random soak against the model. Blanking is sparse to get long data runs.
    m_tally  = -8;
    run_disp = -8;
    for (int n = 0; n < 10000; n++) begin
      data_in    = 8'($urandom);
      control_in = 2'($urandom);
      ve_in      = ($urandom_range(0, 15) != 0);
      d_prev     = data_in;
      ve_prev    = ve_in;
      if (ve_in) begin
        model_step(data_in, m_tally, exp_sym, m_next);
      end else begin
        exp_sym = ctrl_tok[control_in];
        m_next  = 0;
      end
      m_tally = m_next;
      step();
      check("soak_sym", int'(tmds_out), int'(exp_sym));
      check("soak_tally", dut_tally(), m_tally);
      if (ve_prev) begin
        run_disp += disparity(tmds_out);
        check("soak_decode", int'(decode(tmds_out)), int'(d_prev));
        check("soak_tally_range", int'(dut_tally() >= -10 && dut_tally() <= 10), 1);
        check("soak_run_disparity", int'(run_disp >= -10 && run_disp <= 10), 1);
      end else begin
        run_disp = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
